// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: the decoded control bundle and datapath widths.
package mips_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       aluSrc;
        logic [1:0] aluOp;
        logic       regDst;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection; a same-cycle flush overrides the stall so a redirect
// is never blocked.
module hazard_detect #(
    parameter int RW = mips_pkg::RW
) (
    input  logic          ID_EX_memRead,
    input  logic [RW-1:0] ID_EX_regRt,
    input  logic [RW-1:0] IF_ID_regRs,
    input  logic [RW-1:0] IF_ID_regRt,
    input  logic          flush,
    output logic          hazard,
    output logic          pcWrite,
    output logic          IF_ID_write
);

    logic w_rt_match;

    assign w_rt_match  = (ID_EX_regRt == IF_ID_regRs) || (ID_EX_regRt == IF_ID_regRt);
    // Loads into $0 never produce a real value, so they cannot create a dependency.
    assign hazard      = ID_EX_memRead && (ID_EX_regRt != '0) && w_rt_match;
    assign pcWrite     = !(hazard && !flush);
    assign IF_ID_write = !(hazard && !flush);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Optional stall-cycle counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage #(
    parameter int DW = mips_pkg::DW,
    parameter int RW = mips_pkg::RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          ID_regWrite,
    input  logic          ID_memRead,
    input  logic          ID_memWrite,
    input  logic          ID_memToReg,
    input  logic          ID_aluSrc,
    input  logic [1:0]    ID_aluOp,
    input  logic          ID_regDst,
    input  logic [DW-1:0] ID_readData_1,
    input  logic [DW-1:0] ID_readData_2,
    input  logic [DW-1:0] ID_extended_imm,
    input  logic [RW-1:0] IF_ID_regRs,
    input  logic [RW-1:0] IF_ID_regRt,
    input  logic [RW-1:0] IF_ID_regRd,
    output logic          ID_EX_regWrite,
    output logic          ID_EX_memRead,
    output logic          ID_EX_memWrite,
    output logic          ID_EX_memToReg,
    output logic          ID_EX_aluSrc,
    output logic [1:0]    ID_EX_aluOp,
    output logic          ID_EX_regDst,
    output logic [DW-1:0] ID_EX_readData_1,
    output logic [DW-1:0] ID_EX_readData_2,
    output logic [DW-1:0] ID_EX_extended_imm,
    output logic [RW-1:0] ID_EX_regRs,
    output logic [RW-1:0] ID_EX_regRt,
    output logic [RW-1:0] ID_EX_regRd,
    output logic          pcWrite,
    output logic          IF_ID_write
`ifdef ID_EX_STALL_CNT_EN
   ,output logic [31:0]   stall_cnt
`endif
);

    import mips_pkg::ctrl_t;
    import mips_pkg::CTRL_NOP;

    ctrl_t         w_ctrl_in;
    ctrl_t         r_ctrl;
    logic [DW-1:0] r_rd1;
    logic [DW-1:0] r_rd2;
    logic [DW-1:0] r_imm;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [RW-1:0] r_rd;
    logic          w_hazard;

    assign w_ctrl_in = {ID_regWrite, ID_memRead, ID_memWrite, ID_memToReg,
                        ID_aluSrc, ID_aluOp, ID_regDst};

    hazard_detect #(.RW(RW)) u_hazard (
        .ID_EX_memRead (r_ctrl.memRead),
        .ID_EX_regRt   (r_rt),
        .IF_ID_regRs   (IF_ID_regRs),
        .IF_ID_regRt   (IF_ID_regRt),
        .flush         (flush),
        .hazard        (w_hazard),
        .pcWrite       (pcWrite),
        .IF_ID_write   (IF_ID_write)
    );

    // Bubbles only zero the control bits; data fields are don't-care under a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= CTRL_NOP;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_imm  <= '0;
            r_rs   <= '0;
            r_rt   <= '0;
            r_rd   <= '0;
        end else begin
            r_ctrl <= (flush || w_hazard) ? CTRL_NOP : w_ctrl_in;
            r_rd1  <= ID_readData_1;
            r_rd2  <= ID_readData_2;
            r_imm  <= ID_extended_imm;
            r_rs   <= IF_ID_regRs;
            r_rt   <= IF_ID_regRt;
            r_rd   <= IF_ID_regRd;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_hazard && !flush && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign ID_EX_regWrite     = r_ctrl.regWrite;
    assign ID_EX_memRead      = r_ctrl.memRead;
    assign ID_EX_memWrite     = r_ctrl.memWrite;
    assign ID_EX_memToReg     = r_ctrl.memToReg;
    assign ID_EX_aluSrc       = r_ctrl.aluSrc;
    assign ID_EX_aluOp        = r_ctrl.aluOp;
    assign ID_EX_regDst       = r_ctrl.regDst;
    assign ID_EX_readData_1   = r_rd1;
    assign ID_EX_readData_2   = r_rd2;
    assign ID_EX_extended_imm = r_imm;
    assign ID_EX_regRs        = r_rs;
    assign ID_EX_regRt        = r_rt;
    assign ID_EX_regRd        = r_rd;

endmodule
